sat_cnt_cmd_fifo: RTL

//  Command buffer directly upstream of the saturating up/down counter stage.

---
 rtl/sat_cnt_cmd_fifo_pkg.sv | 15 +
 rtl/sat_cnt_cmd_mem.sv | 24 ++
 rtl/sat_cnt_cmd_fifo.sv | 111 +++++++++++
 3 files changed

// File: rtl/sat_cnt_cmd_fifo_pkg.sv
// Shared command types for the saturating counter path.
// Mode encodings and the packed {mode, data} command bundle.
package sat_cnt_pkg;

  localparam int CMD_DATA_W = 8;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  typedef struct packed {
    logic                  mode;
    logic [CMD_DATA_W-1:0] data;
  } sat_cmd_t;

endpackage

// File: rtl/sat_cnt_cmd_mem.sv
// Command storage: DEPTH x W register array.
// One synchronous write port, one asynchronous read port.
module sat_cnt_cmd_mem #(
  parameter  int W     = 9,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sat_cnt_cmd_fifo.sv
// In-order command FIFO feeding the saturating up/down counter.
// Define SAT_CNT_CMD_FIFO_STATUS_EN to add level and ovf_sticky outputs.
module sat_cnt_cmd_fifo
  import sat_cnt_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mode,
  output logic [DATA_W-1:0] out_data,
`ifdef SAT_CNT_CMD_FIFO_STATUS_EN
  output logic [AW:0]       level,
  output logic              ovf_sticky,
`endif
  output logic              full,
  output logic              empty
);

  typedef struct packed {
    logic              mode;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  cmd_t          wr_cmd, head;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign in_ready  = !full && !rst && !flush;
  assign out_valid = !empty;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign wr_cmd = '{mode: in_mode, data: in_data};

  sat_cnt_cmd_mem #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_cmd),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Stale storage is masked so an empty FIFO presents an all-zero command.
  assign out_mode = empty ? MODE_DOWN : head.mode;
  assign out_data = empty ? '0 : head.data;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef SAT_CNT_CMD_FIFO_STATUS_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst || flush)                ovf_q <= 1'b0;
    else if (in_valid && !in_ready)  ovf_q <= 1'b1;
  end

  assign level      = count_q;
  assign ovf_sticky = ovf_q;
`endif

endmodule
